// File: rtl/edge_frame_writer.sv
// Edge frame writer: stores Sobel edge flags as bytes in a frame memory,
// optionally framed by one border row above and below the image body.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start              begin a frame (honoured only when idle)
//   pix_valid, pix_bit one Sobel result per valid cycle (1 = edge)
//   proc_finished      level, processor has emitted its last pixel
//   mem_addr/data/we   registered frame-memory write port
//   busy, done         activity level, one-cycle completion pulse
//   overflow           sticky, more pixels offered than WIDTH*HEIGHT
//
// Build option: define EDGE_FRAME_WRITER_BORDER_EN to emit the head and
// tail border rows. Without it, start goes straight to the body and
// proc_finished goes straight to completion.

module edge_frame_writer #(
    parameter int          WIDTH      = 224,
    parameter int          HEIGHT     = 224,
    parameter logic [7:0]  BORDER_PIX = 8'hE0,
    parameter int          ADDR_W     = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pix_valid,
    input  logic              pix_bit,
    input  logic              proc_finished,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = $clog2(WIDTH * HEIGHT + 1);

    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [PW-1:0] BODY_CAP = PW'(WIDTH * HEIGHT);

    typedef enum logic [2:0] {
        IDLE,
        HEAD,
        BODY,
        TAIL,
        DONE
    } state_t;

    state_t            state;
    logic [CW-1:0]     col;
    logic [PW-1:0]     npix;
    logic [ADDR_W-1:0] wptr;

    // wptr is the address of the next write; mem_addr holds the
    // address of the write currently presented on the port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            col      <= '0;
            npix     <= '0;
            wptr     <= '0;
            mem_addr <= '0;
            mem_data <= '0;
            mem_we   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        wptr     <= '0;
                        col      <= '0;
                        npix     <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
`ifdef EDGE_FRAME_WRITER_BORDER_EN
                        state    <= HEAD;
`else
                        state    <= BODY;
`endif
                    end
                end
                HEAD: begin
                    mem_we   <= 1'b1;
                    mem_data <= BORDER_PIX;
                    mem_addr <= wptr;
                    wptr     <= wptr + 1'b1;
                    col      <= col + 1'b1;
                    if (col == COL_LAST) begin
                        col   <= '0;
                        state <= BODY;
                    end
                end
                BODY: begin
                    // A pixel offered together with proc_finished is
                    // dropped: the frame is closed on that edge.
                    if (proc_finished) begin
`ifdef EDGE_FRAME_WRITER_BORDER_EN
                        col   <= '0;
                        state <= TAIL;
`else
                        done  <= 1'b1;
                        state <= DONE;
`endif
                    end else if (pix_valid) begin
                        if (npix == BODY_CAP) begin
                            overflow <= 1'b1;
                        end else begin
                            mem_we   <= 1'b1;
                            mem_data <= pix_bit ? 8'hFF : 8'h00;
                            mem_addr <= wptr;
                            wptr     <= wptr + 1'b1;
                            npix     <= npix + 1'b1;
                        end
                    end
                end
                TAIL: begin
                    mem_we   <= 1'b1;
                    mem_data <= BORDER_PIX;
                    mem_addr <= wptr;
                    wptr     <= wptr + 1'b1;
                    col      <= col + 1'b1;
                    if (col == COL_LAST) begin
                        col   <= '0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edge_frame_writer.sv
// Scoreboard bench for edge_frame_writer with WIDTH=4, HEIGHT=2.
// Expected writes are queued by the stimulus and popped by a monitor.

module tb_edge_frame_writer;

    localparam int WIDTH  = 4;
    localparam int HEIGHT = 2;
    localparam int ADDR_W = 5;
    localparam int CAP    = WIDTH * HEIGHT;
    localparam int BPIX   = 8'hE0;
`ifdef EDGE_FRAME_WRITER_BORDER_EN
    localparam int BW = WIDTH;
`else
    localparam int BW = 0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              pix_valid = 1'b0;
    logic              pix_bit = 1'b0;
    logic              proc_finished = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              mem_we;
    logic              busy;
    logic              done;
    logic              overflow;

    edge_frame_writer #(
        .WIDTH(WIDTH),
        .HEIGHT(HEIGHT),
        .BORDER_PIX(8'hE0),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .pix_valid(pix_valid),
        .pix_bit(pix_bit),
        .proc_finished(proc_finished),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .mem_we(mem_we),
        .busy(busy),
        .done(done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t q[$];
    int  checks   = 0;
    int  failures = 0;
    int  done_cnt = 0;
    int  exp_addr = 0;
    int  body_n   = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (mem_we) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: addr %0d data %0h",
                         mem_addr, mem_data);
            end else begin
                wr_t e;
                e = q.pop_front();
                if (int'(mem_addr) != e.addr || int'(mem_data) != e.data) begin
                    failures++;
                    $display("FAIL write: got addr %0d data %0h expected addr %0d data %0h",
                             mem_addr, mem_data, e.addr, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int a, input int d);
        wr_t e;
        e.addr = a;
        e.data = d;
        q.push_back(e);
    endtask

    task automatic begin_frame();
        done_cnt = 0;
        body_n   = 0;
        for (int i = 0; i < BW; i++) push(i, BPIX);
        exp_addr = BW;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        chk("ovf_clear_on_start", int'(overflow), 0);
        repeat (BW) tick();
    endtask

    task automatic pix(input logic b);
        if (body_n < CAP) begin
            push(exp_addr, b ? 8'hFF : 8'h00);
            exp_addr++;
        end
        body_n++;
        pix_valid = 1'b1;
        pix_bit   = b;
        tick();
        pix_valid = 1'b0;
        pix_bit   = 1'b0;
    endtask

    task automatic end_frame(input logic drop_pix, input int exp_ovf);
        int t;
        for (int i = 0; i < BW; i++) push(exp_addr + i, BPIX);
        proc_finished = 1'b1;
        pix_valid     = drop_pix;
        pix_bit       = drop_pix;
        tick();
        pix_valid = 1'b0;
        pix_bit   = 1'b0;
        t = 0;
        while (!done && t < 50) begin
            tick();
            t++;
        end
        chk("done_seen", int'(done), 1);
        chk("overflow", int'(overflow), exp_ovf);
        start = 1'b1;
        tick();
        start = 1'b0;
        proc_finished = 1'b0;
        chk("busy_after_done", int'(busy), 0);
        chk("done_one_cycle", int'(done), 0);
        repeat (3) tick();
        chk("queue_drained", q.size(), 0);
        chk("done_pulses", done_cnt, 1);
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_data", int'(mem_data), 0);
        chk("rst_we", int'(mem_we), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ovf", int'(overflow), 0);
        rst = 1'b0;
        tick();

        // Basic frame with pattern 1,0,1,1,0,0,1,0.
        begin_frame();
        pix(1); pix(0); pix(1); pix(1);
        pix(0); pix(0); pix(1); pix(0);
        end_frame(1'b0, 0);

        // Valid every other cycle; addresses stay contiguous.
        begin_frame();
        pix(0); tick(); pix(1); tick();
        pix(1); tick(); pix(0); tick();
        end_frame(1'b0, 0);

        // Ten pixels: last two dropped, overflow raised.
        begin_frame();
        for (int i = 0; i < 10; i++) pix(logic'(i % 3 == 0));
        end_frame(1'b0, 1);

        // Pixel coincident with proc_finished is dropped.
        begin_frame();
        pix(1); pix(1); pix(0);
        end_frame(1'b1, 0);

        // Reset in the middle of the body.
        begin_frame();
        pix(1); pix(0);
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_addr", int'(mem_addr), 0);
        chk("midrst_data", int'(mem_data), 0);
        chk("midrst_we", int'(mem_we), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        repeat (2) tick();
        rst = 1'b0;
        pix_valid = 1'b1;
        pix_bit   = 1'b1;
        repeat (2) tick();
        pix_valid = 1'b0;
        pix_bit   = 1'b0;
        chk("midrst_no_writes", q.size(), 0);
        chk("midrst_idle", int'(busy), 0);

        // Fresh frame restarts at address 0.
        begin_frame();
        pix(0); pix(1); pix(1);
        end_frame(1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
